// File: rtl/bp_me_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_me_pkg                                                           |
// | Shared types and widths for the ME LCE command burst arbiter.      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package bp_me_pkg;

    localparam int lce_cmd_msg_header_width_lp = 64;
    localparam int dword_width_gp              = 64;

    typedef enum logic [1:0] {
        e_arb_idle     = 2'd0,
        e_arb_hdr_lock = 2'd1,
        e_arb_data     = 2'd2
    } bp_me_lce_cmd_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/bp_me_rr_select.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_me_rr_select                                                     |
// | Cyclic priority search starting at ptr_i; one-hot + encoded result.|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module bp_me_rr_select #(
    parameter  int num_p     = 2,
    localparam int lg_num_lp = (num_p > 1) ? $clog2(num_p) : 1
) (
    input  logic [num_p-1:0]     req_i,
    input  logic [lg_num_lp-1:0] ptr_i,
    output logic [num_p-1:0]     grant_oh_o,
    output logic [lg_num_lp-1:0] grant_idx_o,
    output logic                 found_o
);

    localparam int              c_idx_w   = lg_num_lp + 1;
    localparam logic [c_idx_w-1:0] c_num  = c_idx_w'(num_p);
    localparam logic [num_p-1:0] c_one    = num_p'(1);

    logic [c_idx_w-1:0] w_idx;

    // Explicit compare-and-subtract wrap keeps non-power-of-2 counts correct.
    always_comb begin
        w_idx       = '0;
        grant_idx_o = '0;
        found_o     = 1'b0;
        for (int i = 0; i < num_p; i++) begin
            w_idx = {1'b0, ptr_i} + c_idx_w'(i);
            if (w_idx >= c_num) begin
                w_idx = w_idx - c_num;
            end
            if (!found_o && req_i[w_idx[lg_num_lp-1:0]]) begin
                found_o     = 1'b1;
                grant_idx_o = w_idx[lg_num_lp-1:0];
            end
        end
        grant_oh_o = found_o ? (c_one << grant_idx_o) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/bp_me_lce_cmd_burst_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_me_lce_cmd_burst_arbiter                                         |
// | Burst-granular round-robin arbiter for the outbound LCE cmd channel.|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module bp_me_lce_cmd_burst_arbiter
    import bp_me_pkg::*;
#(
    parameter  int num_src_p      = 2,
    parameter  int header_width_p = lce_cmd_msg_header_width_lp,
    parameter  int data_width_p   = dword_width_gp,
    parameter  int max_beats_p    = 8,
    localparam int lg_src_lp      = $clog2(num_src_p)
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [num_src_p*header_width_p-1:0] src_header_i,
    input  logic [num_src_p-1:0]                src_header_has_data_i,
    input  logic [num_src_p-1:0]                src_header_v_i,
    output logic [num_src_p-1:0]                src_header_ready_and_o,
    input  logic [num_src_p*data_width_p-1:0]   src_data_i,
    input  logic [num_src_p-1:0]                src_data_last_i,
    input  logic [num_src_p-1:0]                src_data_v_i,
    output logic [num_src_p-1:0]                src_data_ready_and_o,
    output logic [header_width_p-1:0]           out_header_o,
    output logic                                out_header_v_o,
    input  logic                                out_header_ready_and_i,
    output logic [data_width_p-1:0]             out_data_o,
    output logic                                out_data_last_o,
    output logic                                out_data_v_o,
    input  logic                                out_data_ready_and_i,
    output logic [lg_src_lp-1:0]                grant_o,
    output logic                                busy_o,
    output logic                                error_o
);

    // Counter holds max_beats_p+1 so an overrun stays visible until last.
    localparam int                   c_cnt_w     = $clog2(max_beats_p + 2);
    localparam logic [c_cnt_w-1:0]   c_max_beats = c_cnt_w'(max_beats_p);
    localparam logic [lg_src_lp-1:0] c_last_src  = lg_src_lp'(num_src_p - 1);
    localparam logic [num_src_p-1:0] c_one       = num_src_p'(1);

    bp_me_lce_cmd_arb_state_e r_state, w_state_next;
    logic [lg_src_lp-1:0] r_rr_ptr, w_rr_ptr_next;
    logic [lg_src_lp-1:0] r_grant, w_grant_next;
    logic [c_cnt_w-1:0]   r_beat_cnt, w_beat_cnt_next;
    logic                 r_error, w_error_next;

    logic [num_src_p-1:0] w_win_oh, w_hdr_oh, w_grant_oh;
    logic [lg_src_lp-1:0] w_win_idx, w_hdr_sel;
    logic                 w_win_found, w_hdr_active, w_in_data;
    logic                 w_hdr_hs, w_data_hs;

    function automatic logic [lg_src_lp-1:0] f_rr_inc(input logic [lg_src_lp-1:0] idx);
        return (idx == c_last_src) ? '0 : idx + 1'b1;
    endfunction

    bp_me_rr_select #(.num_p(num_src_p)) u_rr_select (
        .req_i       (src_header_v_i),
        .ptr_i       (r_rr_ptr),
        .grant_oh_o  (w_win_oh),
        .grant_idx_o (w_win_idx),
        .found_o     (w_win_found)
    );

    assign w_grant_oh = c_one << r_grant;
    assign w_hdr_sel  = (r_state == e_arb_idle) ? w_win_idx : r_grant;
    assign w_hdr_oh   = (r_state == e_arb_idle)     ? w_win_oh   :
                        (r_state == e_arb_hdr_lock) ? w_grant_oh : '0;
    assign w_hdr_active = ((r_state == e_arb_idle) && w_win_found)
                       || ((r_state == e_arb_hdr_lock) && src_header_v_i[r_grant]);
    assign w_in_data  = (r_state == e_arb_data) && !reset_i;

    assign out_header_o           = src_header_i[w_hdr_sel*header_width_p +: header_width_p];
    assign out_header_v_o         = w_hdr_active && !reset_i;
    assign src_header_ready_and_o = reset_i ? '0 : (w_hdr_oh & {num_src_p{out_header_ready_and_i}});
    assign w_hdr_hs               = out_header_v_o && out_header_ready_and_i;

    assign out_data_o           = src_data_i[r_grant*data_width_p +: data_width_p];
    assign out_data_last_o      = src_data_last_i[r_grant];
    assign out_data_v_o         = w_in_data && src_data_v_i[r_grant];
    assign src_data_ready_and_o = w_in_data ? (w_grant_oh & {num_src_p{out_data_ready_and_i}}) : '0;
    assign w_data_hs            = out_data_v_o && out_data_ready_and_i;

    assign grant_o = r_grant;
    assign busy_o  = (r_state != e_arb_idle);
    assign error_o = r_error;

    always_comb begin
        w_state_next    = r_state;
        w_rr_ptr_next   = r_rr_ptr;
        w_grant_next    = r_grant;
        w_beat_cnt_next = r_beat_cnt;
        w_error_next    = r_error;
        case (r_state)
            e_arb_idle: begin
                if (w_win_found) begin
                    w_grant_next = w_win_idx;
                    if (!w_hdr_hs) begin
                        w_state_next = e_arb_hdr_lock;
                    end else if (src_header_has_data_i[w_win_idx]) begin
                        w_state_next = e_arb_data;
                    end else begin
                        w_rr_ptr_next = f_rr_inc(w_win_idx);
                    end
                end
            end
            e_arb_hdr_lock: begin
                if (w_hdr_hs) begin
                    if (src_header_has_data_i[r_grant]) begin
                        w_state_next = e_arb_data;
                    end else begin
                        w_state_next  = e_arb_idle;
                        w_rr_ptr_next = f_rr_inc(r_grant);
                    end
                end
            end
            e_arb_data: begin
                if (w_data_hs) begin
                    if (r_beat_cnt >= c_max_beats) begin
                        w_error_next = 1'b1;
                    end
                    if (out_data_last_o) begin
                        w_state_next    = e_arb_idle;
                        w_beat_cnt_next = '0;
                        w_rr_ptr_next   = f_rr_inc(r_grant);
                    end else if (r_beat_cnt <= c_max_beats) begin
                        w_beat_cnt_next = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: w_state_next = e_arb_idle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= e_arb_idle;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_beat_cnt <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_grant    <= w_grant_next;
            r_beat_cnt <= w_beat_cnt_next;
            r_error    <= w_error_next;
        end
    end

endmodule
`default_nettype wire
